// File: rtl/sequence_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sequence_detector_pkg
// Description : State encoding, passcodes and next-state helper for the
//               serial passcode detector.
// Revision    : 1.0 - initial release
// ============================================================================
package sequence_detector_pkg;

    // Each state names the longest stream suffix that is a prefix of a passcode.
    typedef enum logic [2:0] {
        S_E     = 3'd0,
        S_0     = 3'd1,
        S_01    = 3'd2,
        S_010   = 3'd3,
        S_1     = 3'd4,
        S_10    = 3'd5,
        S_100   = 3'd6,
        S_MATCH = 3'd7
    } state_t;

    localparam logic [3:0] PASS_A = 4'b0101;
    localparam logic [3:0] PASS_B = 4'b1001;

    function automatic state_t nextState(input state_t cur, input logic bitIn);
        state_t nxt;
        nxt = S_E;
        case (cur)
            S_E:     nxt = bitIn ? S_1     : S_0;
            S_0:     nxt = bitIn ? S_01    : S_0;
            S_01:    nxt = bitIn ? S_1     : S_010;
            S_010:   nxt = bitIn ? S_MATCH : S_100;
            S_1:     nxt = bitIn ? S_1     : S_10;
            S_10:    nxt = bitIn ? S_01    : S_100;
            S_100:   nxt = bitIn ? S_MATCH : S_0;
            // Both passcodes end in "01", so a match resumes from that suffix.
            S_MATCH: nxt = bitIn ? S_1     : S_010;
            default: nxt = S_E;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sequence_detector.sv
`default_nettype none
// ============================================================================
// Module      : sequence_detector
// Description : Moore FSM pulsing detectOut for one cycle whenever the last
//               four serial bits equal 0101 or 1001 (overlaps allowed).
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_detector
    import sequence_detector_pkg::*;
(
    input  logic clk,
    input  logic asyncReset,
    input  logic dataIn,
    output logic detectOut
);

    state_t r_state;
    state_t w_nextState;
    logic   r_detect;

    always_comb begin
        w_nextState = nextState(r_state, dataIn);
    end

    // The output flop is loaded from the decoded next state so it always
    // equals (r_state == S_MATCH) without a combinational path to the port.
    always_ff @(posedge clk or posedge asyncReset) begin
        if (asyncReset) begin
            r_state  <= S_E;
            r_detect <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_detect <= (w_nextState == S_MATCH);
        end
    end

    assign detectOut = r_detect;

endmodule
`default_nettype wire

// File: tb/tb_sequence_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequence_detector
// Description : Self-checking bench for sequence_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_detector;

    logic clk;
    logic asyncReset;
    logic dataIn;
    logic detectOut;

    int total = 0;
    int bad   = 0;

    logic       expQ[$];
    logic [3:0] win;
    int         nBits;

    typedef struct {
        logic rstFirst;
        logic din;
        logic exp;
    } vec_t;

    vec_t vecs[24];

    sequence_detector dut (
        .clk        (clk),
        .asyncReset (asyncReset),
        .dataIn     (dataIn),
        .detectOut  (detectOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Asserts reset between edges, checks the output clears with no clock.
    task automatic doReset(input string name);
        asyncReset = 1'b1;
        #1;
        check(name, detectOut, 1'b0);
        @(negedge clk);
        asyncReset = 1'b0;
        win   = 4'b0000;
        nBits = 0;
    endtask

    // Drives one bit; expectation comes from the table or the window model.
    task automatic stepBit(input string name, input logic b, input logic tableExp,
                           input logic useModel);
        logic modelExp;
        dataIn = b;
        @(posedge clk);
        win   = {win[2:0], b};
        nBits = nBits + 1;
        modelExp = (nBits >= 4) && (win == 4'b0101 || win == 4'b1001);
        expQ.push_back(useModel ? modelExp : tableExp);
        #1;
        check(name, detectOut, expQ.pop_front());
    endtask

    initial begin
        logic [3:0] w;

        // Test 1: 01010101 -> pulses after bits 4, 6, 8
        vecs[0]  = '{1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1};
        // Test 2: 100101 then 11 -> pulses after bits 4 and 6 only
        vecs[8]  = '{1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0};
        // Test 6: 00001111 -> never asserts
        vecs[16] = '{1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 1'b0};

        asyncReset = 1'b0;
        dataIn     = 1'b0;
        win        = 4'b0000;
        nBits      = 0;
        #2;
        doReset("reset_initial");

        for (int i = 0; i < 24; i++) begin
            if (vecs[i].rstFirst) doReset($sformatf("reset_vec%0d", i));
            stepBit($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp, 1'b0);
        end

        // Test 3: reset mid-sequence discards 010, so a following 1 is no match
        doReset("reset_t3");
        stepBit("t3_b0", 1'b0, 1'b0, 1'b0);
        stepBit("t3_b1", 1'b1, 1'b0, 1'b0);
        stepBit("t3_b2", 1'b0, 1'b0, 1'b0);
        #2;
        doReset("t3_reset_mid");
        stepBit("t3_after", 1'b1, 1'b0, 1'b0);
        stepBit("t3_after2", 1'b0, 1'b0, 1'b0);

        // Test 4: reset during the match pulse clears it before the next edge
        doReset("reset_t4");
        stepBit("t4_b0", 1'b0, 1'b0, 1'b0);
        stepBit("t4_b1", 1'b1, 1'b0, 1'b0);
        stepBit("t4_b2", 1'b0, 1'b0, 1'b0);
        stepBit("t4_b3", 1'b1, 1'b1, 1'b0);
        #2;
        doReset("t4_reset_in_pulse");
        stepBit("t4_after", 1'b1, 1'b0, 1'b0);

        // Test 5: all 16 words back to back against the sliding-window model
        doReset("reset_t5");
        for (int k = 0; k < 16; k++) begin
            w = k[3:0];
            for (int j = 3; j >= 0; j--) begin
                stepBit($sformatf("t5_w%0d_b%0d", k, j), w[j], 1'b0, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
